// File: rtl/bmu_result_skid_if.sv
// Result handshake between the byte unit, the two-entry skid buffer and writeback.
// The slave side is the buffer itself; the master side drives inputs and consumes outputs.
interface bmu_result_skid_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             InValid;
  logic [WIDTH-1:0] InResult;
  logic [TAGW-1:0]  InTag;
  logic             InReady;
  logic             OutValid;
  logic [WIDTH-1:0] OutResult;
  logic [TAGW-1:0]  OutTag;
  logic             OutReady;
  logic             Flush;
  logic [1:0]       Count;

  modport slave (
    input  InValid, InResult, InTag, OutReady, Flush,
    output InReady, OutValid, OutResult, OutTag, Count
  );

  modport master (
    output InValid, InResult, InTag, OutReady, Flush,
    input  InReady, OutValid, OutResult, OutTag, Count
  );
endinterface

// File: rtl/bmu_result_skid.sv
// Two-entry skid buffer decoupling the rev8/orc.b byte unit from writeback.
// Main is always the head; InReady is registered so no OutReady path reaches the producer.
module bmu_result_skid #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  bmu_result_skid_if.slave   bus
);

  logic             main_vld_p0, skid_vld_p1;
  logic             main_vld_nxt, skid_vld_nxt;
  logic             in_rdy_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] main_res_p0, skid_res_p1;
  logic [TAGW-1:0]  main_tag_p0, skid_tag_p1;
  logic             in_xfer, out_xfer;
  logic             main_ld, main_from_skid, skid_ld;

  assign in_xfer  = bus.InValid & in_rdy_q & ~bus.Flush;
  assign out_xfer = main_vld_p0 & ~bus.Flush & bus.OutReady;

  // Skid is only ever occupied while main is, so main-empty implies skid-empty.
  always_comb begin
    main_vld_nxt   = main_vld_p0;
    skid_vld_nxt   = skid_vld_p1;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (bus.Flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (!main_vld_p0) begin
      main_vld_nxt = in_xfer;
      main_ld      = in_xfer;
    end else if (out_xfer) begin
      if (skid_vld_p1) begin
        main_ld        = 1'b1;
        main_from_skid = 1'b1;
        skid_vld_nxt   = in_xfer;
        skid_ld        = in_xfer;
      end else begin
        main_vld_nxt = in_xfer;
        main_ld      = in_xfer;
      end
    end else if (in_xfer) begin
      skid_vld_nxt = 1'b1;
      skid_ld      = 1'b1;
    end
  end

  // p0/p1 control: valids, registered ready and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_vld_p0 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_rdy_q    <= 1'b1;
      cnt_q       <= 2'd0;
    end else begin
      main_vld_p0 <= main_vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      in_rdy_q    <= ~skid_vld_nxt;
      cnt_q       <= {1'b0, main_vld_nxt} + {1'b0, skid_vld_nxt};
    end
  end

  // p0/p1 data: loaded only on demand, otherwise held
  always_ff @(posedge clk) begin
    if (main_ld) begin
      main_res_p0 <= main_from_skid ? skid_res_p1 : bus.InResult;
      main_tag_p0 <= main_from_skid ? skid_tag_p1 : bus.InTag;
    end
    if (skid_ld) begin
      skid_res_p1 <= bus.InResult;
      skid_tag_p1 <= bus.InTag;
    end
  end

  assign bus.InReady   = in_rdy_q;
  assign bus.OutValid  = main_vld_p0 & ~bus.Flush;
  assign bus.OutResult = main_res_p0;
  assign bus.OutTag    = main_tag_p0;
  assign bus.Count     = cnt_q;

endmodule

// File: doc/bmu_result_skid.md
BMU_RESULT_SKID -- requirements
Module: bmu_result_skid

Interface
REQ-001 SHALL take parameter WIDTH, default 32, as the datapath width (XLEN); legal values are 32 and 64.
REQ-002 SHALL take parameter TAGW, default 5, as the destination-register tag width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port InValid, input, 1 bit: the upstream byte unit presents a result.
REQ-006 SHALL have port InResult, input, WIDTH bits: the rev8/orc.b result from the byte unit.
REQ-007 SHALL have port InTag, input, TAGW bits: the destination register of that result.
REQ-008 SHALL have port InReady, output, 1 bit: the block can accept a result this cycle.
REQ-009 SHALL have port OutValid, output, 1 bit: the head entry is presented downstream.
REQ-010 SHALL have port OutResult, output, WIDTH bits: the head entry's result.
REQ-011 SHALL have port OutTag, output, TAGW bits: the head entry's tag.
REQ-012 SHALL have port OutReady, input, 1 bit: writeback accepts the head entry.
REQ-013 SHALL have port Flush, input, 1 bit: discard all held entries (pipeline flush).
REQ-014 SHALL have port Count, output, 2 bits: number of valid entries held (0..2).

Function
REQ-015 SHALL hold two entries, main and skid, each with valid/result/tag state; main is always the head.
REQ-016 SHALL drive InReady as a registered signal equal to NOT skid-valid, with no combinational path from OutReady.
REQ-017 SHALL define the input transfer as InValid AND InReady AND NOT Flush, and the output transfer as OutValid AND OutReady.
REQ-018 SHALL drive OutValid = main-valid AND NOT Flush; OutResult and OutTag = main entry fields.
REQ-019 SHALL deliver results in acceptance order with no loss and no duplication; latency, input transfer to OutValid, is 1 cycle when empty.
REQ-020 SHALL load an input into main when main is empty, or when main drains in the same cycle and skid is empty.
REQ-021 SHALL, when main is full, not draining, and an input transfer occurs, place the input in skid and deassert InReady the next cycle.
REQ-022 SHALL, when main drains while skid is valid, move skid into main; if an input transfer coincides, that input lands in skid.
REQ-023 SHALL, with Count=2, still complete an output transfer, and SHALL reassert InReady the cycle after.
REQ-024 SHALL give Flush priority over every other event: no transfers occur in that cycle; both valids clear at the edge; Count=0 and InReady=1 next cycle.
REQ-025 SHALL set Count = main-valid + skid-valid, registered, consistent with the valids in every cycle.
REQ-026 SHALL keep result/tag registers unchanged when not loaded; data registers need no reset.
REQ-027 SHALL keep OutResult/OutTag stable while OutValid=1 and OutReady=0.

Reset
REQ-028 SHALL, on reset_n low, immediately clear both valids: OutValid=0, Count=0, InReady=1, independent of clk.
REQ-029 SHALL, on reset asserted mid-transfer, discard all held entries; the first accept after reset_n rises occurs at the first rising edge with InValid=1.

Verification
REQ-030 Empty, single beat: InValid=1, InResult=0x01020304, InTag=5, OutReady=1 -> next cycle OutValid=1, OutResult=0x01020304, OutTag=5; Count=1, then 0.
REQ-031 Back-pressure fill: OutReady=0, push 0xAAAAAAAA then 0x55555555 -> Count=2, InReady=0; a third InValid is not accepted; release OutReady -> outputs 0xAAAAAAAA then 0x55555555 in order.
REQ-032 Simultaneous drain and fill at Count=2: OutReady=1 plus InValid with 0x12345678 in the cycle after InReady reasserts -> order preserved; Count never exceeds 2.
REQ-033 Flush at Count=2 with InValid=1 and OutReady=1 in the same cycle -> no transfer either side; next cycle Count=0, OutValid=0, InReady=1.
REQ-034 Async reset pulse between edges at Count=1 -> OutValid falls before the next clk edge; Count=0; the next push is delivered normally.
REQ-035 Random stream of 1000 results with random InValid/OutReady/Flush -> scoreboard shows exact in-order delivery of all non-flushed results; Flush drops only held entries.
